// File: rtl/data_bus_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_bus_dma_pkg
//  Purpose  : Shared types and constants for the data-bus DMA engine:
//             FSM state encoding, bus device codes and IO sub-codes, and a
//             helper that builds an IO address from a sub-code and offset.
//  Options  : DATA_BUS_DMA_FILL_EN (fill mode, see data_bus_dma)
//  Revision : 1.0  initial release
// ============================================================================
package data_bus_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_RD_GAP = 3'd2,
    S_WR_REQ = 3'd3,
    S_WR_GAP = 3'd4,
    S_FINISH = 3'd5
  } dma_state_e;

  // Bus device codes live in address bits [15:12].
  localparam logic [3:0] DEV_MEM    = 4'h0;
  localparam logic [3:0] DEV_ONCHIP = 4'h1;
  localparam logic [3:0] DEV_IO     = 4'h2;

  // IO sub-codes live in address bits [11:8] when the device is DEV_IO.
  localparam logic [3:0] S_DEV_HEX   = 4'h0;
  localparam logic [3:0] S_DEV_SW    = 4'h1;
  localparam logic [3:0] S_DEV_LEDR  = 4'h2;
  localparam logic [3:0] S_DEV_KEY   = 4'h3;
  localparam logic [3:0] S_DEV_TIMER = 4'h4;
  localparam logic [3:0] S_DEV_PS2   = 4'h5;

  function automatic logic [15:0] io_addr(input logic [3:0] sub, input logic [7:0] off);
    return {DEV_IO, sub, off};
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_bus_dma_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_bus_dma_if
//  Purpose  : Command and data-bus signals of the DMA engine.
//  Modports : master - the DMA engine (drives bus requests, status)
//             slave  - command issuer / bus responder side
//  Signals  : cmd_start/src/dst/len (+cmd_fill with DATA_BUS_DMA_FILL_EN),
//             busy, done, error, words_left, read_data, write_data,
//             data_addr, wr_data, rd_data, data_done
//  Revision : 1.0  initial release
// ============================================================================
interface data_bus_dma_if #(
  parameter int ADDR_W = 16
);
  logic              cmd_start;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_len;
`ifdef DATA_BUS_DMA_FILL_EN
  logic              cmd_fill;
`endif
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] words_left;
  logic              read_data;
  logic              write_data;
  logic [ADDR_W-1:0] data_addr;
  logic [15:0]       wr_data;
  logic [15:0]       rd_data;
  logic              data_done;

  modport master (
`ifdef DATA_BUS_DMA_FILL_EN
    input  cmd_fill,
`endif
    input  cmd_start, cmd_src, cmd_dst, cmd_len, rd_data, data_done,
    output busy, done, error, words_left, read_data, write_data,
           data_addr, wr_data
  );

  modport slave (
`ifdef DATA_BUS_DMA_FILL_EN
    output cmd_fill,
`endif
    output cmd_start, cmd_src, cmd_dst, cmd_len, rd_data, data_done,
    input  busy, done, error, words_left, read_data, write_data,
           data_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/data_bus_dma_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : dma_timeout_ctr
//  Purpose  : 8-bit request watchdog. Counts cycles while en is high;
//             expired flags the cycle whose increment reaches TIMEOUT.
//  Ports    : clk, rst (async, active high), clr, en -> expired
//  Revision : 1.0  initial release
// ============================================================================
module dma_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= 8'd0;
    else if (clr)
      to_cnt <= 8'd0;
    else if (en && to_cnt != 8'(TIMEOUT))
      to_cnt <= to_cnt + 8'd1;
  end

  // Asserted on the edge that would bring the count to TIMEOUT, so the
  // request is held for exactly TIMEOUT cycles without a response.
  assign expired = en && (to_cnt == 8'(TIMEOUT - 1));
endmodule
`default_nettype wire

// File: rtl/data_bus_dma.sv
`default_nettype none
// ============================================================================
//  Module   : data_bus_dma
//  Purpose  : Bus-initiator DMA. Copies cmd_len words from cmd_src to
//             cmd_dst, one read then one write per word, each followed by
//             a mandatory idle gap cycle. Aborts with error on timeout.
//  Ports    : clk, rst (async, active high), bus (data_bus_dma_if.master)
//  Options  : DATA_BUS_DMA_FILL_EN - adds cmd_fill; when set, cmd_src is a
//             constant written to every destination word (no reads).
//  Revision : 1.0  initial release
// ============================================================================
module data_bus_dma
  import data_bus_dma_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  data_bus_dma_if.master bus
);
  dma_state_e        state;
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [ADDR_W-1:0] cnt;
  logic [15:0]       data_reg;
  logic              error_r;
  logic              fill_mode;
  logic              start_fill;
  logic              in_req;
  logic              to_expired;

`ifdef DATA_BUS_DMA_FILL_EN
  assign start_fill = bus.cmd_fill;
`else
  assign start_fill = 1'b0;
`endif

  assign in_req = (state == S_RD_REQ) || (state == S_WR_REQ);

  // Every REQ state is entered from a non-REQ state, so holding the
  // counter clear outside REQ states gives a fresh count on each entry.
  dma_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_req),
    .en      (in_req && !bus.data_done),
    .expired (to_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      cnt       <= '0;
      data_reg  <= '0;
      error_r   <= 1'b0;
      fill_mode <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_start) begin
            cur_src   <= bus.cmd_src;
            cur_dst   <= bus.cmd_dst;
            cnt       <= bus.cmd_len;
            error_r   <= 1'b0;
            fill_mode <= start_fill;
            if (start_fill)
              data_reg <= 16'(bus.cmd_src);
            if (bus.cmd_len == '0)
              state <= S_FINISH;
            else if (start_fill)
              state <= S_WR_REQ;
            else
              state <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (bus.data_done) begin
            data_reg <= bus.rd_data;
            state    <= S_RD_GAP;
          end else if (to_expired) begin
            error_r <= 1'b1;
            state   <= S_FINISH;
          end
        end
        S_RD_GAP: state <= S_WR_REQ;
        S_WR_REQ: begin
          if (bus.data_done) begin
            cur_dst <= cur_dst + ADDR_W'(1);
            if (!fill_mode)
              cur_src <= cur_src + ADDR_W'(1);
            cnt   <= cnt - ADDR_W'(1);
            state <= S_WR_GAP;
          end else if (to_expired) begin
            error_r <= 1'b1;
            state   <= S_FINISH;
          end
        end
        S_WR_GAP: begin
          if (cnt == '0)
            state <= S_FINISH;
          else if (fill_mode)
            state <= S_WR_REQ;
          else
            state <= S_RD_REQ;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs decode from state only, so an async reset removes a
  // pending request in the same cycle.
  assign bus.read_data  = (state == S_RD_REQ);
  assign bus.write_data = (state == S_WR_REQ);
  assign bus.data_addr  = (state == S_RD_REQ) ? cur_src :
                          (state == S_WR_REQ) ? cur_dst : '0;
  assign bus.wr_data    = (state == S_WR_REQ) ? data_reg : 16'h0000;
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_FINISH);
  assign bus.error      = error_r;
  assign bus.words_left = cnt;
endmodule
`default_nettype wire

// File: tb/tb_data_bus_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_bus_dma
//  Purpose  : Self-checking bench for data_bus_dma with a memory-backed
//             bus responder (1 wait cycle for mem/onchip, 2 for IO).
//  Options  : DATA_BUS_DMA_FILL_EN enables the fill-mode scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_bus_dma;
  import data_bus_dma_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_bus_dma_if #(.ADDR_W(16)) bus ();

  data_bus_dma #(.TIMEOUT(255), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] wr_log [0:15];
  int wr_idx = 0;
  int wait_cnt = 0;
  logic resp_en = 1'b1;
  logic fill_req = 1'b0;

  int rd_cycles = 0;
  int wr_cycles = 0;
  int both_cycles = 0;
  int done_cycles = 0;

  // Responder: registered done after a device-dependent number of waits.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_done <= 1'b0;
      bus.rd_data   <= 16'h0000;
      wait_cnt = 0;
    end else begin
      bus.data_done <= 1'b0;
      if ((bus.read_data || bus.write_data) && !bus.data_done && resp_en) begin
        if (wait_cnt >= ((bus.data_addr[15:12] == DEV_IO) ? 1 : 0)) begin
          wait_cnt = 0;
          bus.data_done <= 1'b1;
          if (bus.read_data)
            bus.rd_data <= mem[bus.data_addr];
          else begin
            mem[bus.data_addr] = bus.wr_data;
            if (wr_idx < 16) wr_log[wr_idx] = bus.data_addr;
            wr_idx++;
          end
        end else
          wait_cnt++;
      end else
        wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (bus.read_data) rd_cycles++;
    if (bus.write_data) wr_cycles++;
    if (bus.read_data && bus.write_data) both_cycles++;
    if (bus.done) done_cycles++;
  end

  task automatic clear_mon();
    rd_cycles = 0; wr_cycles = 0; both_cycles = 0; done_cycles = 0; wr_idx = 0;
  endtask

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic start(input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] l, input logic f);
    bus.cmd_src = s; bus.cmd_dst = d; bus.cmd_len = l;
    fill_req = f;
`ifdef DATA_BUS_DMA_FILL_EN
    bus.cmd_fill = fill_req;
`endif
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      if (bus.done) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0h want 0", bus.done); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got %0h want 0", bus.error); end
    checks++; if (bus.words_left !== 16'h0) begin errors++; $display("FAIL reset_words_left got %h want 0000", bus.words_left); end
    checks++; if ({bus.read_data, bus.write_data} !== 2'b00) begin errors++; $display("FAIL reset_req got %b want 00", {bus.read_data, bus.write_data}); end
    checks++; if (bus.data_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", bus.data_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mem_copy();
    int cyc;
    logic [15:0] exp [4] = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
    for (int i = 0; i < 4; i++) begin mem[16'h0010 + i] = exp[i]; mem[16'h0020 + i] = 16'h0; end
    clear_mon();
    start(16'h0010, 16'h0020, 16'd4, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL copy_busy got %0h want 1", bus.busy); end
    checks++; if (bus.read_data !== 1'b1 || bus.data_addr !== 16'h0010) begin errors++; $display("FAIL copy_first_read got rd=%0h addr=%h want rd=1 addr=0010", bus.read_data, bus.data_addr); end
    wait_done(40, cyc);
    checks++; if (cyc != 25) begin errors++; $display("FAIL copy_done_cycle got %0d want 25", cyc); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL copy_error got %0h want 0", bus.error); end
    checks++; if (bus.words_left !== 16'd0) begin errors++; $display("FAIL copy_words_left got %0d want 0", bus.words_left); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL copy_after got busy=%0h done=%0h want 0 0", bus.busy, bus.done); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[16'h0020 + i] !== exp[i]) begin errors++; $display("FAIL copy_data[%0d] got %h want %h", i, mem[16'h0020 + i], exp[i]); end
    end
    checks++; if (both_cycles != 0 || done_cycles != 1) begin errors++; $display("FAIL copy_req_excl got both=%0d done=%0d want 0 1", both_cycles, done_cycles); end
  endtask

  task automatic test_zero_len();
    int cyc;
    clear_mon();
    start(16'h0010, 16'h0030, 16'd0, 1'b0);
    wait_done(5, cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL zero_done_cycle got %0d want 1", cyc); end
    @(negedge clk);
    checks++; if (rd_cycles + wr_cycles != 0) begin errors++; $display("FAIL zero_bus_traffic got %0d want 0", rd_cycles + wr_cycles); end
  endtask

  task automatic test_timeout();
    int cyc;
    clear_mon();
    resp_en = 1'b0;
    start(16'h0010, 16'h0040, 16'd5, 1'b0);
    wait_done(300, cyc);
    checks++; if (cyc != 256) begin errors++; $display("FAIL to_done_cycle got %0d want 256", cyc); end
    checks++; if (rd_cycles != 255) begin errors++; $display("FAIL to_read_cycles got %0d want 255", rd_cycles); end
    checks++; if (bus.error !== 1'b1 || bus.read_data !== 1'b0) begin errors++; $display("FAIL to_error got err=%0h rd=%0h want 1 0", bus.error, bus.read_data); end
    checks++; if (bus.words_left !== 16'd5) begin errors++; $display("FAIL to_words_left got %0d want 5", bus.words_left); end
    @(negedge clk);
    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL to_sticky got %0h want 1", bus.error); end
    resp_en = 1'b1;
  endtask

  task automatic test_wrap();
    int cyc;
    mem[16'h0FFF] = 16'h1234; mem[16'h1000] = 16'h5678;
    mem[16'hFFFF] = 16'h0; mem[16'h0000] = 16'h0;
    clear_mon();
    start(16'h0FFF, 16'hFFFF, 16'd2, 1'b0);
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL wrap_err_clear got %0h want 0", bus.error); end
    wait_done(30, cyc);
    checks++; if (cyc != 13) begin errors++; $display("FAIL wrap_done_cycle got %0d want 13", cyc); end
    checks++; if (wr_log[0] !== 16'hFFFF || wr_log[1] !== 16'h0000) begin errors++; $display("FAIL wrap_addrs got %h %h want ffff 0000", wr_log[0], wr_log[1]); end
    checks++; if (mem[16'hFFFF] !== 16'h1234 || mem[16'h0000] !== 16'h5678) begin errors++; $display("FAIL wrap_data got %h %h want 1234 5678", mem[16'hFFFF], mem[16'h0000]); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL wrap_error got %0h want 0", bus.error); end
    @(negedge clk);
  endtask

  task automatic test_restart_and_reset();
    int guard;
    clear_mon();
    start(16'h0010, 16'h0050, 16'd4, 1'b0);
    @(negedge clk);
    bus.cmd_src = 16'h0FFF; bus.cmd_dst = 16'h0060; bus.cmd_len = 16'd1;
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.words_left !== 16'd4) begin errors++; $display("FAIL restart_ignored got busy=%0h left=%0d want 1 4", bus.busy, bus.words_left); end
    guard = 0;
    while (!bus.write_data && guard < 10) begin @(negedge clk); guard++; end
    checks++; if (bus.write_data !== 1'b1 || bus.data_addr !== 16'h0050 || bus.wr_data !== 16'h00A1) begin errors++; $display("FAIL restart_write got wr=%0h addr=%h data=%h want 1 0050 00a1", bus.write_data, bus.data_addr, bus.wr_data); end
    rst = 1'b1;
    #1;
    checks++; if (bus.write_data !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_mid got wr=%0h busy=%0h want 0 0", bus.write_data, bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done_cycles != 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_no_done got done=%0d busy=%0h want 0 0", done_cycles, bus.busy); end
  endtask

`ifdef DATA_BUS_DMA_FILL_EN
  task automatic test_fill();
    int cyc;
    logic [15:0] base;
    base = io_addr(S_DEV_LEDR, 8'h00);
    for (int i = 0; i < 3; i++) mem[base + i] = 16'h0;
    clear_mon();
    start(16'h0055, base, 16'd3, 1'b1);
    wait_done(30, cyc);
    checks++; if (cyc != 13) begin errors++; $display("FAIL fill_done_cycle got %0d want 13", cyc); end
    checks++; if (rd_cycles != 0 || wr_idx != 3) begin errors++; $display("FAIL fill_traffic got rd=%0d wr=%0d want 0 3", rd_cycles, wr_idx); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wr_log[i] !== 16'h2200 + 16'(i) || mem[16'h2200 + i] !== 16'h0055) begin errors++; $display("FAIL fill_word[%0d] got addr=%h data=%h want %h 0055", i, wr_log[i], mem[16'h2200 + i], 16'h2200 + 16'(i)); end
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    bus.cmd_start = 1'b0;
    bus.cmd_src = 16'h0; bus.cmd_dst = 16'h0; bus.cmd_len = 16'h0;
`ifdef DATA_BUS_DMA_FILL_EN
    bus.cmd_fill = 1'b0;
`endif
    test_reset();
    test_mem_copy();
    test_zero_len();
    test_timeout();
    test_wrap();
    test_restart_and_reset();
`ifdef DATA_BUS_DMA_FILL_EN
    test_fill();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
